// File: rtl/game_pkg.sv
// Shared types and constants for the stickman runner game controller.
// Also holds the packed-BCD increment used by the score counter.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PLAYING = 2'd1,
      DYING   = 2'd2,
      OVER    = 2'd3
   } game_state_t;

   localparam logic [7:0] START_KEY = 8'h28;
   localparam logic [7:0] JUMP_KEY  = 8'h2c;
   localparam logic [9:0] H_VIS     = 10'd640;
   localparam logic [9:0] V_VIS     = 10'd480;

   // +1 on four packed BCD digits; 9999 holds instead of wrapping
   function automatic logic [15:0] bcd_inc4(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      if (v == 16'h9999) begin
         r = v;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (carry) begin
               if (r[4*i +: 4] == 4'd9) begin
                  r[4*i +: 4] = 4'd0;
                  carry       = 1'b1;
               end else begin
                  r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                  carry       = 1'b0;
               end
            end else begin
               carry = 1'b0;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit packed BCD counter: synchronous clear (priority), increment
// enable, saturating at 9999.
module bcd_counter4
   import game_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        inc,
   output logic [15:0] value
);

   logic [15:0] value_q;
   logic [15:0] value_d;

   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = 16'h0000;
      end else if (inc) begin
         value_d = bcd_inc4(value_q);
      end else begin
         value_d = value_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         value_q <= 16'h0000;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/game_ctrl.sv
// Game-state controller: collision/fall detection, IDLE/PLAYING/DYING/OVER
// sequencing, and BCD score / high score tracking.
module game_ctrl
   import game_pkg::*;
#(
   parameter logic [9:0] FALL_Y       = 10'd470,
   parameter logic [7:0] DEATH_FRAMES = 8'd60
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic [7:0]  keycode,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        is_stickman,
   input  logic        is_obstacle,
   input  logic [9:0]  StickmanBottom,
   output logic        playing,
   output logic        dying,
   output logic        game_over,
   output logic [15:0] score,
   output logic [15:0] high_score
);

   game_state_t state_q, state_d;
   logic        fc_dly_q;
   logic        frame_edge_q, frame_edge_d;
   logic [7:0]  key_prev_q;
   logic        hit_flag_q, hit_flag_d;
   logic [7:0]  death_cnt_q, death_cnt_d;
   logic [15:0] high_score_q, high_score_d;
   logic        playing_q, playing_d;
   logic        dying_q, dying_d;
   logic        game_over_q, game_over_d;
   logic        start_evt, hit_now, died;
   logic        score_clr, score_inc;
   logic [15:0] score_val;

   bcd_counter4 u_score (
      .clk   (Clk),
      .reset (Reset),
      .clr   (score_clr),
      .inc   (score_inc),
      .value (score_val)
   );

   always_comb begin
      start_evt    = (keycode == START_KEY) && (key_prev_q != START_KEY);
      hit_now      = is_stickman & is_obstacle & (DrawX < H_VIS) & (DrawY < V_VIS);
      frame_edge_d = frame_clk & ~fc_dly_q;
      // a hit on the very frame_edge cycle still ends this frame
      died         = hit_flag_q | hit_now | (StickmanBottom >= FALL_Y);
   end

   always_comb begin
      state_d      = state_q;
      death_cnt_d  = death_cnt_q;
      high_score_d = high_score_q;
      hit_flag_d   = 1'b0;
      score_clr    = 1'b0;
      score_inc    = 1'b0;
      case (state_q)
         IDLE, OVER: begin
            if (start_evt) begin
               state_d   = PLAYING;
               score_clr = 1'b1;
            end else begin
               state_d   = state_q;
            end
         end
         PLAYING: begin
            if (frame_edge_q) begin
               if (died) begin
                  state_d     = DYING;
                  death_cnt_d = DEATH_FRAMES - 8'd1;
               end else begin
                  score_inc   = 1'b1;
               end
            end else begin
               hit_flag_d = hit_flag_q | hit_now;
            end
         end
         DYING: begin
            if (frame_edge_q) begin
               if (death_cnt_q == 8'd0) begin
                  state_d      = OVER;
                  high_score_d = (score_val > high_score_q) ? score_val : high_score_q;
               end else begin
                  death_cnt_d  = death_cnt_q - 8'd1;
               end
            end else begin
               death_cnt_d = death_cnt_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      playing_d   = (state_d == PLAYING);
      dying_d     = (state_d == DYING);
      game_over_d = (state_d == OVER);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= IDLE;
         fc_dly_q     <= 1'b0;
         frame_edge_q <= 1'b0;
         key_prev_q   <= 8'h00;
         hit_flag_q   <= 1'b0;
         death_cnt_q  <= 8'd0;
         high_score_q <= 16'h0000;
         playing_q    <= 1'b0;
         dying_q      <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         fc_dly_q     <= frame_clk;
         frame_edge_q <= frame_edge_d;
         key_prev_q   <= keycode;
         hit_flag_q   <= hit_flag_d;
         death_cnt_q  <= death_cnt_d;
         high_score_q <= high_score_d;
         playing_q    <= playing_d;
         dying_q      <= dying_d;
         game_over_q  <= game_over_d;
      end
   end

   assign playing    = playing_q;
   assign dying      = dying_q;
   assign game_over  = game_over_q;
   assign score      = score_val;
   assign high_score = high_score_q;

endmodule
